// File: rtl/vedic_pkg.sv
// rtl/vedic_pkg.sv - shared widths and state encoding for the Vedic MAC back end
package vedic_pkg;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;
  localparam int CNT_W_DEF  = 8;

  // Encoding 2'd3 is unused and steers back to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/vedic_sat_add.sv
// rtl/vedic_sat_add.sv - unsigned accumulator + product add that clips at all-ones
import vedic_pkg::*;

module vedic_sat_add #(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int PROD_W = PROD_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              overflow
);

  logic [ACC_W:0] wide;

  // One extra carry bit decides whether the true sum fits in ACC_W bits.
  always_comb begin
    wide     = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    overflow = wide[ACC_W];
    sum      = overflow ? '1 : wide[ACC_W-1:0];
  end

endmodule

// File: rtl/vedic_mac_accum.sv
// rtl/vedic_mac_accum.sv - framed saturating accumulator behind the 4x4 Vedic multiplier
import vedic_pkg::*;

module vedic_mac_accum #(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat
);

  state_t            state;
  state_t            next_state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  count;
  logic              sat;

  logic              accept;
  logic              handshake;
  logic              illegal;
  logic [ACC_W-1:0]  base_acc;
  logic [CNT_W-1:0]  base_cnt;
  logic              base_sat;
  logic [ACC_W-1:0]  add_sum;
  logic              add_ovf;

  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  assign illegal   = (state == state_t'(2'd3));

  // A beat taken in IDLE opens a fresh frame regardless of what the registers hold.
  assign base_acc = (state == IDLE) ? '0 : acc;
  assign base_cnt = (state == IDLE) ? '0 : count;
  assign base_sat = (state == IDLE) ? 1'b0 : sat;

  vedic_sat_add #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_sat_add (
    .acc      (base_acc),
    .prod     (in_prod),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  // State register; reset and clear both return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs; HOLD blocks input until the result is taken.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !clear;
        if (in_valid && !clear) begin
          next_state = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = !clear;
        if (in_valid && !clear && in_last) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (clear) begin
      next_state = IDLE;
    end
  end

  // Frame registers: zeroed on any frame end, updated on each accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      count <= '0;
      sat   <= 1'b0;
    end else if (clear || handshake || illegal) begin
      acc   <= '0;
      count <= '0;
      sat   <= 1'b0;
    end else if (accept) begin
      acc   <= add_sum;
      count <= (base_cnt == '1) ? base_cnt : base_cnt + CNT_W'(1);
      sat   <= base_sat | add_ovf;
    end
  end

  assign out_acc   = acc;
  assign out_count = count;
  assign out_sat   = sat;

endmodule

// File: tb/tb_vedic_mac_accum.sv
// tb/tb_vedic_mac_accum.sv - self-checking bench for vedic_mac_accum
module tb_vedic_mac_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_prod = 8'd0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_acc;
  logic [7:0]  out_count;
  logic        out_sat;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  // reference model: frame sum as a plain integer, clipped to 16 bits
  bit m_hold = 1'b0;
  int m_sum  = 0;
  int m_cnt  = 0;
  bit m_sat  = 1'b0;

  vedic_mac_accum dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model advances on every rising edge from the inputs held stable across it
  always @(posedge clk) begin
    bit acc_ok;
    int s;
    acc_ok = in_valid && !m_hold && !clear;
    if (rst) begin
      m_hold = 0; m_sum = 0; m_cnt = 0; m_sat = 0;
      started = 1'b1;
    end else if (clear) begin
      m_hold = 0; m_sum = 0; m_cnt = 0; m_sat = 0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 0; m_sum = 0; m_cnt = 0; m_sat = 0;
      end
    end else if (acc_ok) begin
      s = m_sum + int'(in_prod);
      if (s > 65535) begin
        s = 65535;
        m_sat = 1;
      end
      m_sum = s;
      if (m_cnt < 255) m_cnt = m_cnt + 1;
      if (in_last) m_hold = 1;
    end
  end

  // compare process: mid-cycle check of every output against the model
  always @(negedge clk) begin
    if (started && !rst) begin
      chk("model_in_ready", int'(in_ready), int'(!m_hold && !clear));
      chk("model_out_valid", int'(out_valid), int'(m_hold));
      if (m_hold) begin
        chk("model_out_acc", int'(out_acc), m_sum);
        chk("model_out_count", int'(out_count), m_cnt);
        chk("model_out_sat", int'(out_sat), int'(m_sat));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic beat(input logic [7:0] p, input bit l);
    bit r;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = l;
    forever begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #2;
      if (r) break;
      n++;
      if (n > 50) begin
        chk("beat_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result(input string name, input int e_acc, input int e_cnt, input int e_sat);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        chk({name, "_acc"}, int'(out_acc), e_acc);
        chk({name, "_count"}, int'(out_count), e_cnt);
        chk({name, "_sat"}, int'(out_sat), e_sat);
        break;
      end
      n++;
      if (n > 50) begin
        chk({name, "_timeout"}, 0, 1);
        break;
      end
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_acc", int'(out_acc), 0);
    chk("reset_count", int'(out_count), 0);
    @(posedge clk);
    #2;

    // 1: three beats of 225 -> 675, result visible for exactly one cycle
    out_ready = 1'b1;
    beat(8'd225, 1'b0);
    beat(8'd225, 1'b0);
    beat(8'd225, 1'b1);
    wait_result("t1", 16'h02A3, 3, 0);
    @(negedge clk);
    chk("t1_valid_one_cycle", int'(out_valid), 0);
    tick(1);

    // 2: 300 beats of 225 saturate both sum and count
    for (int i = 0; i < 299; i++) beat(8'd225, 1'b0);
    beat(8'd225, 1'b1);
    wait_result("t2", 16'hFFFF, 255, 1);
    tick(1);

    // 3: result held for 5 cycles while consumer stalls
    out_ready = 1'b0;
    beat(8'd10, 1'b0);
    beat(8'd20, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", int'(out_valid), 1);
      chk("t3_hold_acc", int'(out_acc), 30);
      chk("t3_hold_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #2;
    end
    out_ready = 1'b1;
    tick(1);
    @(negedge clk);
    chk("t3_released_valid", int'(out_valid), 0);
    chk("t3_released_in_ready", int'(in_ready), 1);
    tick(1);

    // 4: clear drops the partial frame and blocks a beat offered with it
    beat(8'd50, 1'b0);
    beat(8'd60, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_prod  = 8'd99;
    @(negedge clk);
    chk("t4_clear_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #2;
    clear    = 1'b0;
    in_valid = 1'b0;
    beat(8'd7, 1'b1);
    wait_result("t4", 7, 1, 0);
    tick(1);

    // 5: reset while a result is held
    out_ready = 1'b0;
    beat(8'd5, 1'b1);
    @(negedge clk);
    chk("t5_pre_valid", int'(out_valid), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_valid", int'(out_valid), 0);
    chk("t5_acc", int'(out_acc), 0);
    chk("t5_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #2;

    // 6: single zero-valued beat closing its own frame
    out_ready = 1'b1;
    beat(8'd0, 1'b1);
    wait_result("t6", 0, 1, 0);
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
